// File: rtl/lite16_pkg.sv
// Shared LITE-16 definitions: field layout, widths, fetch FSM encoding.
package lite16_pkg;

    localparam int OPCODE_W  = 4;
    localparam int ADDR_W    = 12;
    localparam int OPERAND_W = 12;

    // Instruction word layout
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int OPND_MSB = 11;
    localparam int OPND_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [OPCODE_W-1:0]  op;
        logic [OPERAND_W-1:0] opnd;
    } instr_t;

    // Split a raw 16-bit word into opcode/operand fields.
    function automatic instr_t split_instr(input logic [OP_MSB:0] w);
        instr_t r;
        r.op   = w[OP_MSB:OP_LSB];
        r.opnd = w[OPND_MSB:OPND_LSB];
        return r;
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: jump load has priority over sequential increment;
// increment wraps naturally at 2^ADDR_W.
module program_counter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Next pc: jump target, pc+1, or hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i)
            pc_d = target_i;
        else if (inc_i)
            pc_d = pc_q + 1'b1;
    end

    // PC register, cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= '0;
        else
            pc_q <= pc_d;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// LITE-16 instruction fetch sequencer: req/ack fetch from imem, holds the
// decoded fields until execute completes, then steps or jumps the pc.
module fetch_unit
    import lite16_pkg::*;
#(
    parameter int ADDR_W  = lite16_pkg::ADDR_W,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic                 imem_req,
    output logic [ADDR_W-1:0]    imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_W-1:0]   imem_data,
    output logic [OPCODE_W-1:0]  codeop,
    output logic [OPERAND_W-1:0] operand,
    output logic                 instr_valid,
    input  logic                 instr_done,
    input  logic                 jmp_take,
    input  logic [ADDR_W-1:0]    jmp_target,
    output logic [ADDR_W-1:0]    pc,
    output logic                 fetch_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    // Counter value seen during the last permitted unacknowledged cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_q;
    instr_t           ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q;
    logic             vld_q;
    logic             err_q;
    logic             retire;
    logic [ADDR_W-1:0] pc_w;

    // Execute retires only while an instruction is actually held.
    assign retire = (state_q == ST_HOLD) && instr_done;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (retire && jmp_take),
        .inc_i    (retire && !jmp_take),
        .target_i (jmp_target),
        .pc_o     (pc_w)
    );

    // Fetch FSM with registered req/valid/err and the instruction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_FETCH;
                        req_q   <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // req_q is high throughout FETCH, so ack is qualified here.
                    if (imem_ack) begin
                        ir_q    <= split_instr(imem_data[OP_MSB:0]);
                        cnt_q   <= '0;
                        req_q   <= 1'b0;
                        vld_q   <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q   <= cnt_q + 1'b1;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_FAULT;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (instr_done) begin
                        vld_q <= 1'b0;
                        if (run) begin
                            state_q <= ST_FETCH;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    // FAULT: quiescent until reset.
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_w;
    assign pc          = pc_w;
    assign codeop      = ir_q.op;
    assign operand     = ir_q.opnd;
    assign instr_valid = vld_q;
    assign fetch_err   = err_q;

    // Bits above the 16-bit word are not part of the instruction format.
    if (INSTR_W > OP_MSB + 1) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^imem_data[INSTR_W-1:OP_MSB+1];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder driven from tasks,
// expected fields queued on each ack and popped when instr_valid rises.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  codeop;
    logic [11:0] operand;
    logic        instr_valid;
    logic        instr_done;
    logic        jmp_take;
    logic [11:0] jmp_target;
    logic [11:0] pc;
    logic        fetch_err;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] opnd;
        logic [11:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [11:0] exp_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(12), .INSTR_W(16), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .codeop      (codeop),
        .operand     (operand),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .jmp_take    (jmp_take),
        .jmp_target  (jmp_target),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_vld"},   32'(instr_valid), 32'd0);
        chk({tag, "_err"},   32'(fetch_err),   32'd0);
        chk({tag, "_op"},    32'(codeop),      32'd0);
        chk({tag, "_opnd"},  32'(operand),     32'd0);
        chk({tag, "_pc"},    32'(pc),          32'd0);
        chk({tag, "_addr"},  32'(imem_addr),   32'd0);
    endtask

    // Bounded wait for a fetch request; ends on a negedge with req high.
    task automatic wait_req(input string tag);
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(imem_req), 32'd1);
    endtask

    // One full instruction: wait for req, ack after `waits` cycles, check
    // the held fields, retire with optional jump.
    task automatic do_fetch(input logic [15:0] word, input int waits,
                            input logic take, input logic [11:0] tgt,
                            input logic run_mid, input logic run_done);
        exp_t        e;
        logic [11:0] a0;
        wait_req("req_up");
        chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
        a0  = imem_addr;
        run = run_mid;
        repeat (waits) begin
            @(negedge clk);
            chk("addr_stable", 32'({imem_req, imem_addr}), 32'({1'b1, a0}));
        end
        imem_ack  = 1'b1;
        imem_data = word;
        sb.push_back('{op: word[15:12], opnd: word[11:0], pc: exp_pc});
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);
        e = sb.pop_front();
        chk("valid_up", 32'(instr_valid), 32'd1);
        chk("req_down", 32'(imem_req),    32'd0);
        chk("codeop",   32'(codeop),      32'(e.op));
        chk("operand",  32'(operand),     32'(e.opnd));
        chk("pc_hold",  32'(pc),          32'(e.pc));
        // Jump without done must be ignored; stray ack must not disturb fields.
        jmp_take   = 1'b1;
        jmp_target = 12'h5A5;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        chk("hold_fields", 32'({instr_valid, codeop, operand, pc}),
            32'({1'b1, e.op, e.opnd, e.pc}));
        run        = run_done;
        instr_done = 1'b1;
        jmp_take   = take;
        jmp_target = tgt;
        @(negedge clk);
        instr_done = 1'b0;
        jmp_take   = 1'b0;
        exp_pc     = take ? tgt : exp_pc + 12'd1;
        chk("valid_down", 32'(instr_valid), 32'd0);
        chk("pc_next",    32'(pc),          32'(exp_pc));
        chk("addr_next",  32'(imem_addr),   32'(exp_pc));
        chk("req_next",   32'(imem_req),    32'(run_done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0;
        instr_done = 1'b0; jmp_take = 1'b0; jmp_target = '0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 32'(imem_req), 32'd0);

        // Ack and done while idle are ignored.
        imem_ack = 1'b1; imem_data = 16'hFFFF; instr_done = 1'b1; jmp_take = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0; instr_done = 1'b0; jmp_take = 1'b0;
        chk("idle_ack_ign", 32'({instr_valid, codeop, pc}), 32'd0);

        // Request appears one cycle after run is seen.
        run = 1'b1;
        @(negedge clk);
        chk("run_req", 32'(imem_req), 32'd1);
        exp_pc = 12'h000;

        do_fetch(16'h3ABC, 0, 1'b0, 12'h000, 1'b1, 1'b1); // pc -> 1
        do_fetch(16'h7123, 3, 1'b1, 12'h050, 1'b1, 1'b1); // pc -> 050
        do_fetch(16'h9000, 1, 1'b1, 12'hFFF, 1'b1, 1'b1); // pc -> FFF
        do_fetch(16'h1111, 0, 1'b0, 12'h000, 1'b1, 1'b1); // wrap -> 0
        do_fetch(16'h2222, 2, 1'b1, 12'h000, 1'b1, 1'b1); // jump to self
        do_fetch(16'hE0F0, 2, 1'b0, 12'h000, 1'b0, 1'b0); // run drops mid-fetch
        repeat (3) begin
            @(negedge clk);
            chk("park_no_req", 32'({imem_req, instr_valid}), 32'd0);
        end

        // Reset mid-FETCH: outputs clear without a clock edge.
        run = 1'b1;
        wait_req("req_pre_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_fetch");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-HOLD.
        exp_pc = 12'h000;
        wait_req("req_pre_hold");
        imem_ack = 1'b1; imem_data = 16'h5A5A;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hold_pre_rst", 32'({instr_valid, codeop, operand}), 32'({1'b1, 16'h5A5A}));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        // Timeout: 15 unacknowledged FETCH cycles then sticky fault.
        wait_req("req_to");
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("to_wait", 32'({fetch_err, imem_req}), 32'd1);
        end
        @(negedge clk);
        chk("to_err", 32'({fetch_err, imem_req, instr_valid}), 32'b100);
        imem_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("fault_quiet", 32'({fetch_err, imem_req, instr_valid}), 32'b100);
        end
        imem_ack = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_fault");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_fault_req", 32'({fetch_err, imem_req}), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
